// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, geometry and address helpers for the direct-mapped cache
package cache_pkg;

    localparam int DATA_W  = 32;
    localparam int INDEX_W = 4;
    localparam int OFFS_W  = 2;
    localparam int TAG_W   = DATA_W - INDEX_W - OFFS_W;
    localparam int LINES   = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WBACK,
        REFILL,
        RESPOND
    } state_e;

    function automatic logic [TAG_W-1:0] get_tag(input logic [DATA_W-1:0] addr);
        return addr[DATA_W-1:OFFS_W+INDEX_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_idx(input logic [DATA_W-1:0] addr);
        return addr[OFFS_W+INDEX_W-1:OFFS_W];
    endfunction

    function automatic logic [OFFS_W-1:0] get_off(input logic [DATA_W-1:0] addr);
        return addr[OFFS_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [INDEX_W-1:0] idx,
                                                    input logic [OFFS_W-1:0] off);
        return {tag, idx, off};
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// rtl/cache_tag_store.sv - tag/valid/dirty arrays with combinational hit and victim lookup
module cache_tag_store
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               hit,
    output logic               victim_valid,
    output logic               victim_dirty,
    output logic [TAG_W-1:0]   victim_tag,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               fill,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic               set_dirty,
    input  logic               clr_dirty
);

    logic [TAG_W-1:0] tags [LINES];
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;

    // Tags carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) tags[wr_idx] <= fill_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (fill) begin
                valid[wr_idx] <= 1'b1;
                dirty[wr_idx] <= 1'b0;
            end
            if (set_dirty) dirty[wr_idx] <= 1'b1;
            if (clr_dirty) dirty[wr_idx] <= 1'b0;
        end
    end

    assign victim_tag   = tags[lookup_idx];
    assign victim_valid = valid[lookup_idx];
    assign victim_dirty = dirty[lookup_idx];
    assign hit          = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-back write-allocate cache controller
module dm_cache_ctrl #(
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int OFFS_W  = cache_pkg::OFFS_W,
    parameter int DATA_W  = cache_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    import cache_pkg::*;

    localparam int DEPTH = 2 ** (INDEX_W + OFFS_W);

    state_e             state;
    logic [OFFS_W-1:0]  cnt;
    logic [OFFS_W-1:0]  nxt;
    logic [OFFS_W-1:0]  pend_off;
    logic               pend;
    logic [DATA_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic               req_we;
    logic [TAG_W-1:0]   wb_tag;
    logic [DATA_W-1:0]  data_q [DEPTH];

    logic [INDEX_W-1:0] cidx, ridx, wr_idx;
    logic [TAG_W-1:0]   ctag, rtag, vtag;
    logic [OFFS_W-1:0]  coff, roff;
    logic               hit, vvalid, vdirty, accept, last, fill_done, set_dirty, clr_dirty;
    logic               dw_en;
    logic [INDEX_W+OFFS_W-1:0] dw_addr;
    logic [DATA_W-1:0]  dw_data;

    assign cidx      = get_idx(cpu_addr);
    assign ctag      = get_tag(cpu_addr);
    assign coff      = get_off(cpu_addr);
    assign ridx      = get_idx(req_addr);
    assign rtag      = get_tag(req_addr);
    assign roff      = get_off(req_addr);
    assign nxt       = cnt + 1'b1;
    assign last      = (cnt == '1);
    // The ready cycle still sees cpu_req held high; ignoring it keeps one request in flight.
    assign accept    = (state == IDLE) && cpu_req && !cpu_ready;
    assign fill_done = (state == REFILL) && pend && (pend_off == '1);
    assign wr_idx    = (state == IDLE) ? cidx : ridx;
    assign set_dirty = (accept && hit && cpu_we) || (state == RESPOND && req_we);
    assign clr_dirty = (state == WBACK) && last;

    cache_tag_store u_tags (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (cidx),
        .lookup_tag   (ctag),
        .hit          (hit),
        .victim_valid (vvalid),
        .victim_dirty (vdirty),
        .victim_tag   (vtag),
        .wr_idx       (wr_idx),
        .fill         (fill_done),
        .fill_tag     (rtag),
        .set_dirty    (set_dirty),
        .clr_dirty    (clr_dirty)
    );

    always_comb begin
        dw_en   = 1'b0;
        dw_addr = {ridx, pend_off};
        dw_data = mem_dout;
        if (accept && hit && cpu_we) begin
            dw_en   = 1'b1;
            dw_addr = {cidx, coff};
            dw_data = cpu_wdata;
        end else if (state == REFILL && pend) begin
            dw_en   = 1'b1;
        end else if (state == RESPOND && req_we) begin
            dw_en   = 1'b1;
            dw_addr = {ridx, roff};
            dw_data = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (dw_en) data_q[dw_addr] <= dw_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            pend_off  <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            wb_tag    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    if (accept) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        cnt       <= '0;
                        pend      <= 1'b0;
                        if (hit) begin
                            cpu_ready <= 1'b1;
                            if (!cpu_we) cpu_rdata <= data_q[{cidx, coff}];
                        end else if (vvalid && vdirty) begin
                            state    <= WBACK;
                            wb_tag   <= vtag;
                            mem_wen  <= 1'b1;
                            mem_addr <= line_addr(vtag, cidx, '0);
                            mem_din  <= data_q[{cidx, {OFFS_W{1'b0}}}];
                        end else begin
                            state    <= REFILL;
                            mem_ren  <= 1'b1;
                            mem_addr <= line_addr(ctag, cidx, '0);
                        end
                    end
                end
                WBACK: begin
                    if (last) begin
                        state    <= REFILL;
                        cnt      <= '0;
                        pend     <= 1'b0;
                        mem_wen  <= 1'b0;
                        mem_ren  <= 1'b1;
                        mem_addr <= line_addr(rtag, ridx, '0);
                    end else begin
                        cnt      <= nxt;
                        mem_addr <= line_addr(wb_tag, ridx, nxt);
                        mem_din  <= data_q[{ridx, nxt}];
                    end
                end
                REFILL: begin
                    // Read data returns one cycle after the strobe, so captures trail issues by one.
                    pend     <= mem_ren;
                    pend_off <= cnt;
                    if (mem_ren) begin
                        cnt <= nxt;
                        if (last) mem_ren <= 1'b0;
                        else      mem_addr <= line_addr(rtag, ridx, nxt);
                    end
                    if (fill_done) begin
                        state     <= RESPOND;
                        cpu_ready <= 1'b1;
                        if (!req_we)
                            cpu_rdata <= (roff == pend_off) ? mem_dout : data_q[{ridx, roff}];
                    end
                end
                RESPOND: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard bench for dm_cache_ctrl against a behavioural word memory
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout = '0;

    logic [31:0] mem [4096];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic hold = 1'b0;

    typedef struct { logic chk; logic [31:0] data; int at; int id; } rsp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] din; } mop_t;
    rsp_t rsp_q[$];
    mop_t mop_q[$];

    dm_cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[11:0]] <= mem_din;
        else if (mem_ren) mem_dout <= mem[mem_addr[11:0]];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Protocol watch: a request must stay up until it is answered.
    always @(posedge clk) begin
        if (rst_n && hold && !cpu_req && !cpu_ready) begin
            n_fail++;
            $display("FAIL protocol: cpu_req dropped before cpu_ready");
        end
        hold = rst_n && cpu_req && !cpu_ready;
    end

    always @(negedge clk) begin
        if (rst_n && cpu_ready) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                rsp_t r;
                r = rsp_q.pop_front();
                check($sformatf("t%0d_latency_edge", r.id), cyc + 1, r.at);
                if (r.chk) check($sformatf("t%0d_rdata", r.id), cpu_rdata, r.data);
            end
        end
        if (rst_n && (mem_ren || mem_wen)) begin
            check("mem_ren_wen_exclusive", {31'd0, mem_ren && mem_wen}, 32'd0);
            if (mop_q.size() == 0) begin
                check("unexpected_mem_op", mem_addr, 32'hFFFF_FFFF);
            end else begin
                mop_t m;
                m = mop_q.pop_front();
                check("mem_op_we", {31'd0, mem_wen}, {31'd0, m.we});
                check("mem_op_addr", mem_addr, m.addr);
                if (m.we) check("mem_op_din", mem_din, m.din);
            end
        end
    end

    task automatic exp_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) mop_q.push_back('{1'b0, base + i, 32'd0});
    endtask

    task automatic exp_wb(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
        mop_q.push_back('{1'b1, base,     d0});
        mop_q.push_back('{1'b1, base + 1, d1});
        mop_q.push_back('{1'b1, base + 2, d2});
        mop_q.push_back('{1'b1, base + 3, d3});
    endtask

    task automatic cpu_op(input int id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int lat);
        logic got;
        @(negedge clk);
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        rsp_q.push_back('{!we, exp, cyc + 1 + lat, id});
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cpu_ready) got = 1'b1;
        end
        cpu_req = 1'b0;
        if (!got) begin
            check($sformatf("t%0d_timeout", id), 32'd0, 32'd1);
            void'(rsp_q.pop_front());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_ready"}, {31'd0, cpu_ready}, 32'd0);
        check({tag, "_mem_ren"},   {31'd0, mem_ren},   32'd0);
        check({tag, "_mem_wen"},   {31'd0, mem_wen},   32'd0);
        check({tag, "_mem_addr"},  mem_addr,           32'd0);
        check({tag, "_mem_din"},   mem_din,            32'd0);
        check({tag, "_cpu_rdata"}, cpu_rdata,          32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = i;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold miss, clean refill
        exp_fill(32'h10);
        cpu_op(1, 1'b0, 32'h10, 32'd0, 32'h10, 6);
        // 2: hit in the freshly filled line
        cpu_op(2, 1'b0, 32'h12, 32'd0, 32'h12, 1);
        // 3: store hit then load hit; memory untouched (write-back)
        cpu_op(3, 1'b1, 32'h11, 32'hDEAD, 32'd0, 1);
        cpu_op(3, 1'b0, 32'h11, 32'd0, 32'hDEAD, 1);
        check("t3_mem_0x11_unchanged", mem[12'h11], 32'h11);
        // 4: conflict miss on dirty line: write back then refill
        exp_wb(32'h10, 32'h10, 32'hDEAD, 32'h12, 32'h13);
        exp_fill(32'h50);
        cpu_op(4, 1'b0, 32'h50, 32'd0, 32'h50, 10);
        check("t4_mem_0x11_written_back", mem[12'h11], 32'hDEAD);
        // 5: store miss allocates, then load returns merged value
        exp_fill(32'h200);
        cpu_op(5, 1'b1, 32'h200, 32'h1234, 32'd0, 6);
        cpu_op(5, 1'b0, 32'h200, 32'd0, 32'h1234, 1);
        cpu_op(5, 1'b0, 32'h203, 32'd0, 32'h203, 1);
        // last word of a line returned straight from the refill
        exp_fill(32'h60);
        cpu_op(7, 1'b0, 32'h63, 32'd0, 32'h63, 6);
        // evict the line dirtied by the store miss
        exp_wb(32'h200, 32'h1234, 32'h201, 32'h202, 32'h203);
        exp_fill(32'h240);
        cpu_op(8, 1'b0, 32'h240, 32'd0, 32'h240, 10);
        check("t8_mem_0x200_written_back", mem[12'h200], 32'h1234);

        // 6: reset in the second refill cycle
        @(negedge clk);
        cpu_we   = 1'b0;
        cpu_addr = 32'h30;
        cpu_req  = 1'b1;
        mop_q.push_back('{1'b0, 32'h30, 32'd0});
        mop_q.push_back('{1'b0, 32'h31, 32'd0});
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_reset_outputs("midmiss");
        check("t6_pending_mem_ops", mop_q.size(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_fill(32'h30);
        cpu_op(6, 1'b0, 32'h30, 32'd0, 32'h30, 6);
        // line that was valid before reset must miss again
        exp_fill(32'h50);
        cpu_op(9, 1'b0, 32'h52, 32'd0, 32'h52, 6);

        repeat (4) @(negedge clk);
        check("leftover_responses", rsp_q.size(), 32'd0);
        check("leftover_mem_ops", mop_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
